// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump engine: default geometry and FSM encoding.
package regdump_pkg;

    localparam int unsigned DefNumRegs = 32;
    localparam int unsigned DefAddrW   = 5;
    localparam int unsigned DefDataW   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StHold,
        StCsum,
        StDone
    } dumpState_e;

endpackage

// File: rtl/regdump_checksum.sv
// Running modulo-2^DATA_W sum of the register words emitted by a dump.
module regdump_checksum
    import regdump_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accEn,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sumQ, sumD;

    always_comb begin
        sumD = sumQ;
        if (clear) begin
            sumD = '0;
        end else if (accEn) begin
            sumD = sumQ + dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sumQ <= '0;
        end else begin
            sumQ <= sumD;
        end
    end

    assign sum = sumQ;

endmodule

// File: rtl/regdump_reader.sv
// Walks a wrap-around register range through a read port and streams each word out.
// Define REGDUMP_CHECKSUM_EN to append a checksum beat after the last register.
module regdump_reader
    import regdump_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic              busy,
    output logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] rsReadData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              out_is_csum,
    output logic              done
);

    dumpState_e        stateQ, stateD;
    logic [ADDR_W-1:0] idxQ, idxD;
    logic [ADDR_W-1:0] endQ, endD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic [ADDR_W-1:0] indexQ, indexD;
    logic              lastQ, lastD;
    logic              atEnd;

    assign atEnd = (idxQ == endQ);

    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        endD   = endQ;
        dataD  = dataQ;
        indexD = indexQ;
        lastD  = lastQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    idxD   = first_reg;
                    endD   = last_reg;
                    stateD = StRead;
                end
            end
            StRead: begin
                dataD  = rsReadData;
                indexD = idxQ;
`ifdef REGDUMP_CHECKSUM_EN
                lastD  = 1'b0;
`else
                lastD  = atEnd;
`endif
                stateD = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    if (!atEnd) begin
                        // Explicit wrap keeps the walk correct for any NUM_REGS.
                        idxD   = (idxQ == ADDR_W'(NUM_REGS - 1)) ? '0 : idxQ + ADDR_W'(1);
                        stateD = StRead;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        stateD = StCsum;
`else
                        stateD = StDone;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            StCsum: begin
                if (out_ready) begin
                    stateD = StDone;
                end
            end
`endif
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StIdle;
            idxQ   <= '0;
            endQ   <= '0;
            dataQ  <= '0;
            indexQ <= '0;
            lastQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            endQ   <= endD;
            dataQ  <= dataD;
            indexQ <= indexD;
            lastQ  <= lastD;
        end
    end

    assign busy      = (stateQ != StIdle);
    assign rs        = idxQ;
    assign done      = (stateQ == StDone);
    assign out_index = indexQ;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csumSum;

    regdump_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  ((stateQ == StIdle) && start),
        .accEn  (stateQ == StRead),
        .dataIn (rsReadData),
        .sum    (csumSum)
    );

    // indexQ already holds the end index on the checksum beat.
    assign out_valid   = (stateQ == StHold) || (stateQ == StCsum);
    assign out_data    = (stateQ == StCsum) ? csumSum : dataQ;
    assign out_last    = (stateQ == StCsum) || lastQ;
    assign out_is_csum = (stateQ == StCsum);
`else
    assign out_valid   = (stateQ == StHold);
    assign out_data    = dataQ;
    assign out_last    = lastQ;
    assign out_is_csum = 1'b0;
`endif

endmodule

// File: tb/tb_regdump_reader.sv
// Scoreboard bench for regdump_reader with a behavioural register file and random dumps.
module tb_regdump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
        logic        isCsum;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic        busy;
    logic [4:0]  rs;
    logic [31:0] rsReadData;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        out_is_csum;
    logic        done;

    logic        regWrite = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] writeData = '0;
    logic [31:0] regs [32] = '{default: '0};
    logic [31:0] shadow [32] = '{default: '0};

    beat_t       sbQ[$];
    int          checks = 0;
    int          passes = 0;
    int          readyMode = 0;
    int          stallCnt = 0;
    bit          stallDone = 0;

    always #5 clk = ~clk;

    // Register file: $zero is read-only, reads are combinational.
    always @(posedge clk) begin
        if (regWrite && rd != 5'd0) regs[rd] <= writeData;
    end
    assign rsReadData = (rs == 5'd0) ? 32'd0 : regs[rs];

    regdump_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_reg   (first_reg),
        .last_reg    (last_reg),
        .busy        (busy),
        .rs          (rs),
        .rsReadData  (rsReadData),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .out_is_csum (out_is_csum),
        .done        (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Sink: always ready, random, one 5-cycle stall on the index-2 beat, or never ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && out_index == 5'd2 && !stallDone) begin
                        if (stallCnt < 5) begin
                            out_ready = 1'b0;
                            stallCnt++;
                        end else begin
                            out_ready = 1'b1;
                            stallDone = 1'b1;
                        end
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stability under backpressure.
    initial begin
        bit    stallPrev;
        beat_t prevBeat;
        beat_t cur;
        beat_t e;
        stallPrev = 0;
        prevBeat = '0;
        forever begin
            @(negedge clk);
            cur = '{data: out_data, index: out_index, last: out_last, isCsum: out_is_csum};
            if (!rst) begin
                stallPrev = 0;
            end else begin
                if (stallPrev) begin
                    check("stall valid held", out_valid, 1);
                    check("stall beat held", cur, prevBeat);
                end
                if (out_valid && out_ready) begin
                    if (sbQ.size() == 0) begin
                        check("unexpected beat", 1, 0);
                    end else begin
                        e = sbQ.pop_front();
                        check("beat data", cur.data, e.data);
                        check("beat index", cur.index, e.index);
                        check("beat last/csum", {cur.last, cur.isCsum}, {e.last, e.isCsum});
                    end
                end
                stallPrev = out_valid && !out_ready;
                prevBeat = cur;
            end
        end
    end

    task automatic writeReg(input logic [4:0] r, input logic [31:0] d);
        @(posedge clk);
        #1;
        regWrite = 1'b1;
        rd = r;
        writeData = d;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        if (r != 5'd0) shadow[r] = d;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " rs"}, rs, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " out_index/last/csum/done"},
              {out_index, out_last, out_is_csum, done}, 0);
    endtask

    task automatic runDump(input logic [4:0] f, input logic [4:0] l, input bit checkLat,
                           input bit midStart);
        int          n;
        int          cyc;
        bit          seen;
        logic [31:0] sum;
        logic [4:0]  idx;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            idx = 5'((int'(f) + k) % 32);
            sbQ.push_back('{data: shadow[idx], index: idx,
                            last: (k == n - 1) && !CsumEn, isCsum: 1'b0});
            sum += shadow[idx];
        end
        if (CsumEn) sbQ.push_back('{data: sum, index: l, last: 1'b1, isCsum: 1'b1});

        @(posedge clk);
        #1;
        start = 1'b1;
        first_reg = f;
        last_reg = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_reg = 5'($urandom);
        last_reg = 5'($urandom);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy after start", busy, 1);
            if (midStart && cyc == 3) begin
                start = 1'b1;
                first_reg = 5'd10;
                last_reg = 5'd20;
            end
            if (midStart && cyc == 4) start = 1'b0;
            if (done) seen = 1;
        end
        if (!seen) begin
            check("done timeout", 0, 1);
        end else begin
            if (checkLat) check("done cycle", cyc - 1, 2 * n + (CsumEn ? 1 : 0));
            check("busy during done", busy, 1);
            @(negedge clk);
            check("done/busy fall", {done, busy}, 2'b00);
        end
        check("all beats seen", sbQ.size(), 0);
        sbQ.delete();
    endtask

    initial begin
        int w;
        // Reset with start pulses that must be ignored.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 2);
            first_reg = 5'd3;
            last_reg = 5'd7;
            checkAllZero("in reset");
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("after reset");

        writeReg(5'd1, 32'd12345);
        writeReg(5'd6, 32'd67890);

        readyMode = 0;
        runDump(5'd1, 5'd6, 1, 0);

        readyMode = 2;
        stallCnt = 0;
        stallDone = 0;
        runDump(5'd1, 5'd6, 0, 0);
        readyMode = 0;

        runDump(5'd30, 5'd1, 1, 0);
        runDump(5'd6, 5'd6, 1, 0);
        runDump(5'd1, 5'd6, 1, 1);

        // Reset in the middle of a stalled beat.
        readyMode = 3;
        @(posedge clk);
        #1;
        start = 1'b1;
        first_reg = 5'd1;
        last_reg = 5'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("reached hold", out_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        readyMode = 0;
        runDump(5'd1, 5'd6, 1, 0);

        writeReg(5'd0, 32'd98765);
        runDump(5'd0, 5'd0, 1, 0);

        readyMode = 1;
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 3; j++) writeReg(5'($urandom), $urandom);
            runDump(5'($urandom), 5'($urandom), 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regdump_reader.md
# regdump_reader

Sequential register-file dump engine for the single-cycle RISC processor. On a start request it walks a contiguous, wrap-around range of architectural registers, drives each index onto a register-file read port (`rs`) and samples `rsReadData`. Each sampled word is presented on a valid/ready stream for a debug/trace sink. It is the reading counterpart to the writeback path that drives `rd`/`regWrite`/`writeData`.

## Interface
- `NUM_REGS`, 32: number of architectural registers; must be a power of two.
- `ADDR_W`, 5: register index width, log2(`NUM_REGS`).
- `DATA_W`, 32: register data width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `start`  in  1  dump request; sampled only in IDLE.
- `first_reg`  in  ADDR_W  first index; sampled with `start`.
- `last_reg`  in  ADDR_W  last index, inclusive; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until DONE is left.
- `rs`  out  ADDR_W  read address to the register-file read port.
- `rsReadData`  in  DATA_W  combinational read data for `rs`.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts beat.
- `out_data`  out  DATA_W  register contents, or checksum.
- `out_index`  out  ADDR_W  register index of the beat.
- `out_last`  out  1  final beat of the dump.
- `out_is_csum`  out  1  beat carries the checksum.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE, READ, HOLD, CSUM, DONE.
- IDLE: on `start`=1, latch `first_reg` into the index counter and `last_reg` into the end register, then go to READ. Any `start` outside IDLE is ignored.
- READ (1 cycle): `rs` = index. At the clock edge, `out_data` <= `rsReadData`, `out_index` <= index, `out_last` <= (index == end) and checksum disabled. Then go to HOLD.
- HOLD: `out_valid`=1. On `out_valid && out_ready`:
  - if index != end: index <= (index+1) mod `NUM_REGS`, go to READ.
  - if index == end: go to CSUM when checksum is enabled, otherwise go to DONE.
- CSUM: `out_valid`=1, `out_data`=checksum, `out_is_csum`=1, `out_last`=1, `out_index`=end. On handshake, go to DONE.
- DONE (1 cycle): `done`=1. Then go to IDLE.
- Range: `first_reg` > `last_reg` wraps through `NUM_REGS`-1 to 0. `first_reg` == `last_reg` produces exactly one beat. A full sweep therefore needs `first_reg` = `last_reg`+1 mod `NUM_REGS`.
- Stability: while `out_valid` && !`out_ready`, `out_data`, `out_index`, `out_last` and `out_is_csum` are held constant. `out_valid` never drops without a handshake.
- Coherency with writeback: a register-file write on the same edge that captures a word is not reflected in that word. The old value is emitted.
- Index 0 always reads 0, because `$zero` is read-only in the register file.

## Timing
- Reset values: `busy`=0, `rs`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `out_is_csum`=0, `done`=0, state=IDLE, checksum=0.
- Reset assertion clears all state immediately, with no clock needed, including in the middle of a dump. The next dump starts cleanly after reset is released.
- `start` sampled at edge E0. READ occupies cycle E0..E1. The first beat is valid from E1.
- With `out_ready` held at 1, throughput is one beat per 2 cycles, so N registers take 2N cycles from E0 to the final handshake.
- `done` is high for exactly the cycle following the final handshake. `busy` falls at the same edge that `done` falls.
- `rs` is a registered output: it equals the index counter and is stable for the whole READ cycle.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined:
  - the checksum accumulates the sum modulo 2^`DATA_W` of every emitted register word, and is cleared on accepted `start`;
  - one extra CSUM beat follows the last register beat;
  - `out_last` is asserted only on the CSUM beat.
- `REGDUMP_CHECKSUM_EN` undefined:
  - the CSUM state and accumulator are absent;
  - `out_is_csum` is tied to 0;
  - `out_last` is asserted on the final register beat.

## Structure
- Shared package/include `regdump_pkg`: FSM state encoding, defaults for `NUM_REGS`, `ADDR_W` and `DATA_W`.
- Sub-module `regdump_checksum` (clear, accumulate-enable, data in, sum out). It is instantiated only under `REGDUMP_CHECKSUM_EN`.
- The bench instantiates the existing RegisterFile, with `rs` driven from this block and `rtReadData` unused.

## Test plan
- Reset: hold `rst`=0 for 5 cycles -> every output 0, `start` pulses ignored while in reset. Release reset -> IDLE.
- Preload `$1`=12345 and `$6`=67890, others 0. `first_reg`=1, `last_reg`=6, `out_ready`=1 -> 6 beats with indices 1..6, data 12345,0,0,0,0,67890, `out_last` on index 6. `done` pulses in cycle 12 after the start edge.
- Backpressure: same dump, `out_ready`=0 for 5 cycles on the index-2 beat -> `out_data`=0 and `out_index`=2 held stable. The dump resumes and still yields 6 beats.
- Wrap: `first_reg`=30, `last_reg`=1 -> indices 30,31,0,1, and the index-0 beat carries 0. Also `first_reg`=`last_reg`=6 -> a single beat of 67890 with `out_last`=1.
- Interference: `start` pulsed mid-dump -> ignored, beat count unchanged. `rst`=0 during HOLD -> outputs 0 immediately, and a new dump afterwards is correct. Write 98765 to `$0` via RegisterFile, then dump index 0 -> data 0.
- With `REGDUMP_CHECKSUM_EN`, range 1..6 -> 7th beat with `out_data`=80235, `out_is_csum`=1 and `out_last`=1. `out_last` is 0 on index 6.
